// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load. Both serial ends and the full parallel word are visible.
// A shift counter pulses word_done after every WIDTH shifts, so the block
// can serve as the front end of a serializer or deserializer.
//
// Parameters:
//   WIDTH      register width in bits, 2..32
//
// Ports:
//   clk        rising-edge clock
//   clear      asynchronous active-low reset
//   en         operation enable; 0 holds register and counter
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r      serial input for right shift, enters q[WIDTH-1]
//   sin_l      serial input for left shift, enters q[0]
//   pdata      parallel load data
//   rot        rotate request (active only with UNIV_SHIFT_REG_ROTATE_EN)
//   q          register contents
//   sout_r     q[0], bit leaving on a right shift
//   sout_l     q[WIDTH-1], bit leaving on a left shift
//   bit_cnt    shifts since last load, reset or word wrap
//   word_done  one-cycle pulse when the WIDTH-th shift of a word completes
//
// Build option:
//   UNIV_SHIFT_REG_ROTATE_EN  when defined, rot=1 feeds the bit leaving the
//                             register back in at the other end (rotate).
// ---------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    bit_cnt,
    output logic             word_done
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             fill_r;
    logic             fill_l;
    logic             shift;

    // Bits entering the register on a shift; in rotate mode they come from
    // the opposite end of the register instead of the serial pins.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign fill_r = rot ? q_q[0]       : sin_r;
    assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign fill_r     = sin_r;
    assign fill_l     = sin_l;
`endif

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        shift  = 1'b0;

        if (en) begin
            case (mode)
                MODE_RIGHT: begin
                    q_d   = {fill_r, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                MODE_LEFT: begin
                    q_d   = {q_q[WIDTH-2:0], fill_l};
                    shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = pdata;
                    cnt_d = '0;
                end
                MODE_HOLD: begin
                    q_d = q_q;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end

        // Both directions advance the same word counter.
        if (shift) begin
            if (cnt_q == LAST_BIT) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q         = q_q;
    assign sout_r    = q_q[0];
    assign sout_l    = q_q[WIDTH-1];
    assign bit_cnt   = cnt_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clear;
    logic          en;
    logic [1:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  pdata;
    logic          rot;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic [CW-1:0] bit_cnt;
    logic          word_done;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .clear     (clear),
        .en        (en),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pdata     (pdata),
        .rot       (rot),
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .bit_cnt   (bit_cnt),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        int           cnt;
        logic         done;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: register value plus total shifts since the word start.
    logic [W-1:0] m_q      = '0;
    int           m_shifts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One operation presented for the next rising edge; expected result queued.
    task automatic step(input logic e, input logic [1:0] md, input logic sr,
                        input logic sl, input logic [W-1:0] pd, input logic rt);
        exp_t x;
        logic b;
        logic did_shift;
        @(negedge clk);
        en = e; mode = md; sin_r = sr; sin_l = sl; pdata = pd; rot = rt;
        did_shift = 1'b0;
        if (e) begin
            if (md == 2'd1) begin
                b   = (ROT && rt) ? m_q[0] : sr;
                m_q = (m_q >> 1) | (W'(b) << (W - 1));
                did_shift = 1'b1;
            end else if (md == 2'd2) begin
                b   = (ROT && rt) ? m_q[W-1] : sl;
                m_q = (m_q << 1) | W'(b);
                did_shift = 1'b1;
            end else if (md == 2'd3) begin
                m_q      = pd;
                m_shifts = 0;
            end
        end
        if (did_shift) m_shifts++;
        x.q    = m_q;
        x.cnt  = m_shifts % W;
        x.done = did_shift && (m_shifts % W == 0);
        sbq.push_back(x);
    endtask

    task automatic shifts(input int n, input logic [1:0] md, input logic s);
        for (int i = 0; i < n; i++) step(1'b1, md, s, s, W'($urandom), 1'b0);
    endtask

    // Idle the DUT and wait for every queued expectation to be checked.
    task automatic drain();
        int k;
        @(negedge clk);
        en = 1'b0; mode = 2'd0;
        k = 0;
        while (sbq.size() > 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() > 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q"}, q, 0);
        chk({tag, "_cnt"}, bit_cnt, 0);
        chk({tag, "_done"}, word_done, 0);
        chk({tag, "_sout_r"}, sout_r, 0);
        chk({tag, "_sout_l"}, sout_l, 0);
    endtask

    // Asynchronous reset pulse placed between edges; checked before any edge.
    task automatic reset_pulse();
        @(negedge clk);
        #1;
        clear = 1'b0;
        en = $urandom; mode = $urandom; pdata = $urandom;
        #1;
        check_zero("rst_pulse");
        en = 1'b0; mode = 2'd0;
        #1;
        clear = 1'b1;
        m_q = '0;
        m_shifts = 0;
    endtask

    // Monitor: every edge out of reset with an outstanding expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (clear === 1'b1 && sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("q", q, x.q);
                chk("bit_cnt", bit_cnt, x.cnt);
                chk("word_done", word_done, x.done);
                chk("sout_r", sout_r, x.q[0]);
                chk("sout_l", sout_l, x.q[W-1]);
            end
        end
    end

    initial begin
        clear = 1'b0; en = 1'b0; mode = 2'd0;
        sin_r = 1'b0; sin_l = 1'b0; pdata = '0; rot = 1'b0;
        #1;
        check_zero("rst_init");
        for (int i = 0; i < 4; i++) begin
            #4;
            en = $urandom; mode = $urandom; sin_r = $urandom;
            sin_l = $urandom; pdata = $urandom; rot = $urandom;
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        en = 1'b0; mode = 2'd0;
        clear = 1'b1;

        // Load A5, then eight right shifts with ones.
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0);
        shifts(8, 2'd1, 1'b1);
        drain();
        chk("right_final_q", q, 8'hFF);
        chk("right_final_cnt", bit_cnt, 0);

        // Load 81, one left shift with zero.
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'h81, 1'b0);
        drain();
        chk("left_sout_l_before", sout_l, 1);
        step(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();
        chk("left_q", q, 8'h02);
        chk("left_cnt", bit_cnt, 1);

        // Enable low and explicit hold both freeze the word.
        step(1'b1, 2'd3, 1'b0, 1'b0, W'($urandom), 1'b0);
        shifts(3, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd1, 1'b0, 1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 2'd0, 1'b1, 1'b1, W'($urandom), 1'b0);
        drain();
        chk("hold_cnt", bit_cnt, 3);

        // Reset mid-word discards the partial count; a load restarts it.
        shifts(5, 2'd2, 1'b1);
        drain();
        reset_pulse();
        shifts(8, 2'd1, 1'b1);
        shifts(5, 2'd2, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'h3C, 1'b0);
        drain();
        chk("load_restart_cnt", bit_cnt, 0);
        shifts(8, 2'd1, 1'b0);
        drain();

        // Rotate walk: 01 returns to 01 when rotating, drains to 00 otherwise.
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1);
        drain();
        chk("rotate_final_q", q, ROT ? 8'h01 : 8'h00);

        // Randomised operation mix with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 50) begin
                drain();
                reset_pulse();
            end
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 9) < 2 ? 3 : $urandom_range(0, 2)),
                 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
